// File: rtl/decodificador_2a4_reg.sv
// rtl/decodificador_2a4_reg.sv - registered 2-to-4 decoder with valid/ready handshakes and error counting
// Optional feature macro ERR_LOCK_EN: lock the input after LOCK_THRESH consecutive error beats.
module decodificador_2a4_reg #(
    parameter int CNT_W       = 8,
    parameter int LOCK_THRESH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             S_1,
    input  logic             S_0,
    input  logic             E,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             D,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    if (LOCK_THRESH < 1 || LOCK_THRESH > (2 ** CNT_W) - 1) begin : g_bad_thresh
        $error("LOCK_THRESH out of range");
    end

`ifdef ERR_LOCK_EN
    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_LOCKED} state_t;
    localparam int CW = $clog2(LOCK_THRESH + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_THRESH);
    logic [CW-1:0] consec_q, consec_d;
    logic          lock_pending;
`else
    typedef enum logic [0:0] {ST_EMPTY, ST_FULL} state_t;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [4:0]       data_q, data_d;      // {A, B, C, D, err}
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             accept, drain;

    assign out_valid = (state_q == ST_FULL);
    assign {A, B, C, D, err} = data_q;
    assign err_count = err_count_q;

`ifdef ERR_LOCK_EN
    // The held beat completed the error run: no more words until it leaves and we lock.
    assign lock_pending = out_valid && (consec_q == LOCK_MAX);
    assign in_ready = (state_q != ST_LOCKED) && !lock_pending && (!out_valid || out_ready);
`else
    assign in_ready = !out_valid || out_ready;
`endif

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    always_comb begin
        data_d      = data_q;
        err_count_d = err_count_q;
        if (accept) begin
            if (E) begin
                data_d = 5'b00001;
                if (err_count_q != CNT_MAX) begin
                    err_count_d = err_count_q + 1'b1;
                end
            end else begin
                case ({S_1, S_0})
                    2'b00:   data_d = 5'b10000;
                    2'b01:   data_d = 5'b01000;
                    2'b10:   data_d = 5'b00100;
                    default: data_d = 5'b00010;
                endcase
            end
        end else if (drain) begin
            data_d = 5'b00000;
        end
    end

`ifdef ERR_LOCK_EN
    always_comb begin
        consec_d = consec_q;
        if (accept) begin
            if (!E) begin
                consec_d = '0;
            end else if (consec_q != LOCK_MAX) begin
                consec_d = consec_q + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (drain && !accept) begin
`ifdef ERR_LOCK_EN
                    state_d = lock_pending ? ST_LOCKED : ST_EMPTY;
`else
                    state_d = ST_EMPTY;
`endif
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            data_q      <= '0;
            err_count_q <= '0;
`ifdef ERR_LOCK_EN
            consec_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            err_count_q <= err_count_d;
`ifdef ERR_LOCK_EN
            consec_q    <= consec_d;
`endif
        end
    end

endmodule

// File: tb/tb_decodificador_2a4_reg.sv
// tb/tb_decodificador_2a4_reg.sv - self-checking bench for decodificador_2a4_reg
module tb_decodificador_2a4_reg;

    localparam int CNT_W  = 8;
    localparam int THRESH = 3;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic S_1 = 1'b0, S_0 = 1'b0, E = 1'b0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic A, B, C, D, err;
    logic [CNT_W-1:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level reference state
    bit       m_valid;
    bit [3:0] m_onehot;   // {A,B,C,D}
    bit       m_err;
    int       m_count;
    int       m_consec;
    bit       m_locked;

    decodificador_2a4_reg #(.CNT_W(CNT_W), .LOCK_THRESH(THRESH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .S_1(S_1), .S_0(S_0), .E(E), .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .C(C), .D(D), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_onehot = 0; m_err = 0; m_count = 0; m_consec = 0; m_locked = 0;
    endtask

    function automatic bit lock_pend();
`ifdef ERR_LOCK_EN
        return m_valid && m_err && (m_consec >= THRESH);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, out_valid, m_valid);
        check({tag, ".abcd"}, {A, B, C, D}, m_onehot);
        check({tag, ".err"}, err, m_err);
        check({tag, ".err_count"}, err_count, m_count);
    endtask

    // One clock: drive a word, check in_ready, advance the model, check outputs.
    task automatic cycle(input bit v, input bit [1:0] code, input bit e, input bit ordy, input string tag);
        bit exp_rdy, acc, drn, pend;
        in_valid  = v;
        out_ready = ordy;
        if (v) begin
            S_1 = code[1]; S_0 = code[0]; E = e;
        end else begin
            S_1 = 1'bx; S_0 = 1'bx; E = 1'bx;
        end
        #1;
        exp_rdy = !m_locked && !lock_pend() && (!m_valid || ordy);
        check({tag, ".in_ready"}, in_ready, exp_rdy);
        @(posedge clk);
        acc  = v && exp_rdy;
        drn  = m_valid && ordy;
        pend = lock_pend();
        if (acc) begin
            m_valid  = 1;
            m_err    = e;
            m_onehot = e ? 4'b0000 : (4'b1000 >> code);
            if (e) begin
                if (m_count < CMAX) m_count++;
                if (m_consec < THRESH) m_consec++;
            end else begin
                m_consec = 0;
            end
        end else if (drn) begin
            m_valid = 0; m_onehot = 0; m_err = 0;
            if (pend) m_locked = 1;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_outputs("reset");
        check("reset.in_ready", in_ready, 1'b1);
    endtask

    initial begin
        model_reset();
        do_reset();

        // Decode sweep, back-to-back
        cycle(1, 2'b00, 0, 1, "sweep00");
        cycle(1, 2'b01, 0, 1, "sweep01");
        cycle(1, 2'b10, 0, 1, "sweep10");
        cycle(1, 2'b11, 0, 1, "sweep11");
        cycle(0, 2'b00, 0, 1, "sweep_drain");

        // Backpressure: second word waits until out_ready rises
        cycle(1, 2'b01, 0, 0, "bp_load");
        for (int i = 0; i < 4; i++) cycle(1, 2'b11, 0, 0, "bp_hold");
        cycle(1, 2'b11, 0, 1, "bp_release");
        cycle(0, 2'b00, 0, 1, "bp_drain");

        // Error beats with various codes
        cycle(1, 2'b11, 1, 1, "err1");
        cycle(1, 2'b00, 1, 1, "err2");
        cycle(1, 2'b10, 1, 1, "err3");
        cycle(0, 2'b00, 0, 1, "err_drain");
        check("err_total", err_count, 3);

        // Reset mid-beat clears outputs without a clock edge
        do_reset();
        cycle(1, 2'b10, 0, 0, "mid_load");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid.out_valid", out_valid, 1'b0);
        check("mid.C", C, 1'b0);
        check("mid.err_count", err_count, 0);
        #2;
        rst_n = 1'b1;
        @(negedge clk);

`ifndef ERR_LOCK_EN
        // Saturation of err_count
        do_reset();
        for (int i = 0; i < CMAX + 2; i++) cycle(1, 2'($urandom), 1, 1, "sat");
        check("sat_final", err_count, CMAX);
        cycle(1, 2'b01, 0, 1, "sat_good");
`else
        // Three consecutive errors lock after the last one drains
        do_reset();
        cycle(1, 2'b00, 1, 1, "lk1");
        cycle(1, 2'b01, 1, 1, "lk2");
        cycle(1, 2'b10, 1, 1, "lk3");
        for (int i = 0; i < 5; i++) cycle(1, 2'b00, 0, 1, "locked");
        check("locked.flag", m_locked, 1'b1);
        // E=1,E=1,E=0,E=1 never locks
        do_reset();
        cycle(1, 2'b00, 1, 1, "nl1");
        cycle(1, 2'b00, 1, 1, "nl2");
        cycle(1, 2'b00, 0, 1, "nl3");
        cycle(1, 2'b00, 1, 1, "nl4");
        for (int i = 0; i < 3; i++) cycle(1, 2'b01, 0, 1, "nl_after");
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
